// File: rtl/ucore_enable_responder_if.sv
// Handshake and status bundle between ucore_main's output port and its responder.
`default_nettype none

interface ucore_enable_responder_if #(
  parameter int CNT_W = 16
);
  logic             valid;
  logic             enable;
  logic             hold;
  logic [CNT_W-1:0] txn_count;
  logic [CNT_W-1:0] stall_count;
  logic             proto_err;
  logic             busy;

  modport master (
    output valid, hold,
    input  enable, txn_count, stall_count, proto_err, busy
  );

  modport slave (
    input  valid, hold,
    output enable, txn_count, stall_count, proto_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/ucore_enable_responder.sv
// ucore_enable_responder: returns enable a programmable delay after valid; counts transfers/stalls.
// Optional macro RESP_JITTER_EN adds 0..3 LFSR-derived cycles to each WAIT delay.
`default_nettype none

module ucore_enable_responder #(
  parameter int RESP_DELAY = 3,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  ucore_enable_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [8:0] c_resp_delay = 9'(RESP_DELAY);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [8:0]       r_dly;
  logic [8:0]       w_dly_nxt;
  logic [8:0]       w_load;
  logic             w_txn_inc;
  logic             w_stall_inc;
  logic             w_err_set;
  logic             r_enable;
  logic             r_busy;
  logic             r_proto_err;
  logic [CNT_W-1:0] r_txn_count;
  logic [CNT_W-1:0] r_stall_count;

`ifdef RESP_JITTER_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; free-running regardless of FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_load = c_resp_delay + {7'd0, r_lfsr[1:0]};
`else
  assign w_load = c_resp_delay;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_txn_inc   = 1'b0;
    w_stall_inc = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.valid) begin
          w_dly_nxt   = w_load;
          w_state_nxt = (w_load == 9'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // a stalled cycle is counted even if valid is dropping in the same cycle
        w_stall_inc = bus.hold;
        if (!bus.valid) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!bus.hold) begin
          if (r_dly == 9'd1) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_dly_nxt = r_dly - 9'd1;
          end
        end
      end
      ST_ACK: begin
        if (bus.valid) begin
          w_txn_inc = 1'b1;
        end else begin
          w_err_set = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_dly         <= 9'd0;
      r_enable      <= 1'b0;
      r_busy        <= 1'b0;
      r_proto_err   <= 1'b0;
      r_txn_count   <= '0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_dly         <= w_dly_nxt;
      r_enable      <= (w_state_nxt == ST_ACK);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_proto_err   <= r_proto_err | w_err_set;
      r_txn_count   <= r_txn_count + {{(CNT_W-1){1'b0}}, w_txn_inc};
      r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, w_stall_inc};
    end
  end

  assign bus.enable      = r_enable;
  assign bus.busy        = r_busy;
  assign bus.proto_err   = r_proto_err;
  assign bus.txn_count   = r_txn_count;
  assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire
